// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory stage: region codes, I/O register
// offsets and STATUS bit positions.
package dmem_mmio_pkg;

    localparam logic [3:0] REGION_RAM = 4'h0;
    localparam logic [3:0] REGION_IO  = 4'h8;

    // I/O register select, taken from Addr[3:2]
    localparam logic [1:0] IO_OUT    = 2'd0;
    localparam logic [1:0] IO_CYCLES = 2'd1;
    localparam logic [1:0] IO_STATUS = 2'd2;
    localparam logic [1:0] IO_RSVD   = 2'd3;

    localparam int STATUS_EMPTY = 0;
    localparam int STATUS_FULL  = 1;
    localparam int STATUS_OVF   = 2;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_IO   = 2'd2
    } region_e;

    function automatic region_e decode_region(input logic [3:0] code);
        region_e r;
        r = SEL_NONE;
        if (code == REGION_RAM) r = SEL_RAM;
        else if (code == REGION_IO) r = SEL_IO;
        return r;
    endfunction

endpackage

// File: rtl/dmem_mmio_fifo.sv
// Synchronous circular-buffer FIFO; pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter.
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory stage: word RAM at region 0x0, plus cycle counter, output FIFO
// and status register at region 0x8. Loads are combinational.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int RW = $clog2(RAM_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);

    logic [31:0]   ram [RAM_WORDS];
    logic [RW-1:0] ram_idx;
    region_e       region;
    logic [1:0]    io_off;

    logic          ram_wr;
    logic          out_wr;
    logic          cyc_wr;
    logic          st_wr;

    logic [31:0]   cycles;
    logic          overflow;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [FW:0]   fifo_count;
    logic [31:0]   status_word;
    logic          unused_bits;

    assign region  = decode_region(Addr[31:28]);
    assign io_off  = Addr[3:2];
    assign ram_idx = Addr[RW+1:2];

    assign ram_wr = MemWrite && (region == SEL_RAM);
    assign out_wr = MemWrite && (region == SEL_IO) && (io_off == IO_OUT);
    assign cyc_wr = MemWrite && (region == SEL_IO) && (io_off == IO_CYCLES);
    assign st_wr  = MemWrite && (region == SEL_IO) && (io_off == IO_STATUS);

    assign fifo_push = out_wr && !fifo_full;
    assign fifo_pop  = out_valid && out_ready;
    assign out_valid = !fifo_empty;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (WriteData),
        .pop       (fifo_pop),
        .head      (out_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (ram_wr) ram[ram_idx] <= WriteData;
    end

    always_ff @(posedge clk) begin
        if (!rst)        cycles <= '0;
        else if (cyc_wr) cycles <= WriteData;
        else             cycles <= cycles + 32'd1;
    end

    // A dropped push and a clear in the same cycle: the set takes priority.
    always_ff @(posedge clk) begin
        if (!rst)                          overflow <= 1'b0;
        else if (out_wr && fifo_full)      overflow <= 1'b1;
        else if (st_wr && WriteData[STATUS_OVF]) overflow <= 1'b0;
    end

    always_comb begin
        status_word               = '0;
        status_word[STATUS_EMPTY] = fifo_empty;
        status_word[STATUS_FULL]  = fifo_full;
        status_word[STATUS_OVF]   = overflow;
    end

    always_comb begin
        ReadData = '0;
        case (region)
            SEL_RAM: ReadData = ram[ram_idx];
            SEL_IO: begin
                case (io_off)
                    IO_CYCLES: ReadData = cycles;
                    IO_STATUS: ReadData = status_word;
                    default:   ReadData = '0;
                endcase
            end
            default: ReadData = '0;
        endcase
    end

    assign unused_bits = ^{Addr[27:RW+2], Addr[1:0], fifo_count};

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: a vector table stepped one cycle per entry,
// followed by a hand-written back-to-back streaming sequence.
module tb_dmem_mmio;

    localparam logic [31:0] A_OUT  = 32'h8000_0000;
    localparam logic [31:0] A_CYC  = 32'h8000_0004;
    localparam logic [31:0] A_ST   = 32'h8000_0008;
    localparam logic [31:0] A_RSV  = 32'h8000_000C;

    localparam logic [2:0] C_NO  = 3'b000;
    localparam logic [2:0] C_RD  = 3'b001;
    localparam logic [2:0] C_V   = 3'b010;
    localparam logic [2:0] C_VD  = 3'b110;

    logic        clk;
    logic        rst;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int checks;
    int errors;

    typedef struct {
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        bit          rdy;
        logic [2:0]  chk;
        logic [31:0] erd;
        bit          ev;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl[$];

    dmem_mmio #(
        .RAM_WORDS  (64),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, bit w, logic [31:0] a, logic [31:0] d, bit rdy,
                                logic [2:0] chk, logic [31:0] erd, bit ev, logic [31:0] ed);
        vec_t v;
        v.r = r; v.w = w; v.a = a; v.d = d; v.rdy = rdy;
        v.chk = chk; v.erd = erd; v.ev = ev; v.ed = ed;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, check before the next rising edge.
    task automatic step(input vec_t v, input string nm);
        @(negedge clk);
        rst       = v.r;
        MemWrite  = v.w;
        Addr      = v.a;
        WriteData = v.d;
        out_ready = v.rdy;
        #1;
        if (v.chk[0]) cmp({nm, ".rd"}, ReadData, v.erd);
        if (v.chk[1]) cmp({nm, ".valid"}, {31'b0, out_valid}, {31'b0, v.ev});
        if (v.chk[2] && v.ev) cmp({nm, ".data"}, out_data, v.ed);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        MemWrite  = 1'b0;
        Addr      = '0;
        WriteData = '0;
        out_ready = 1'b0;

        // reset and counter
        tbl.push_back(mk(0, 0, A_CYC, 0, 0, C_NO, 0, 0, 0));
        tbl.push_back(mk(0, 0, A_ST,  0, 0, C_RD | C_V, 32'd1, 0, 0));
        tbl.push_back(mk(1, 0, A_CYC, 0, 0, C_RD, 32'd0, 0, 0));
        tbl.push_back(mk(1, 0, A_CYC, 0, 0, C_RD, 32'd1, 0, 0));
        tbl.push_back(mk(1, 0, A_CYC, 0, 0, C_RD, 32'd2, 0, 0));
        tbl.push_back(mk(1, 1, A_CYC, 32'hFFFF_FFFE, 0, C_RD, 32'd3, 0, 0));
        tbl.push_back(mk(1, 0, A_CYC, 0, 0, C_RD, 32'hFFFF_FFFE, 0, 0));
        tbl.push_back(mk(1, 0, A_CYC, 0, 0, C_RD, 32'hFFFF_FFFF, 0, 0));
        tbl.push_back(mk(1, 0, A_CYC, 0, 0, C_RD, 32'h0, 0, 0));
        // RAM, aliasing, read-during-write, other regions
        tbl.push_back(mk(1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, C_NO, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0000_0010, 0, 0, C_RD, 32'hDEAD_BEEF, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0000_0013, 0, 0, C_RD, 32'hDEAD_BEEF, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0000_0110, 0, 0, C_RD, 32'hDEAD_BEEF, 0, 0));
        tbl.push_back(mk(1, 1, 32'h0000_0010, 32'hCAFE_F00D, 0, C_RD, 32'hDEAD_BEEF, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0000_0010, 0, 0, C_RD, 32'hCAFE_F00D, 0, 0));
        tbl.push_back(mk(1, 0, A_OUT, 0, 0, C_RD | C_V, 32'h0, 0, 0));
        tbl.push_back(mk(1, 0, A_RSV, 0, 0, C_RD, 32'h0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h4000_0010, 32'h77, 0, C_NO, 0, 0, 0));
        tbl.push_back(mk(1, 1, A_RSV, 32'h99, 0, C_NO, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h4000_0010, 0, 0, C_RD, 32'h0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0000_0010, 0, 0, C_RD | C_V, 32'hCAFE_F00D, 0, 0));
        // fill, overflow, drain
        tbl.push_back(mk(1, 1, A_OUT, 32'd1, 0, C_V, 0, 0, 0));
        tbl.push_back(mk(1, 1, A_OUT, 32'd2, 0, C_VD, 0, 1, 32'd1));
        tbl.push_back(mk(1, 1, A_OUT, 32'd3, 0, C_VD, 0, 1, 32'd1));
        tbl.push_back(mk(1, 1, A_OUT, 32'd4, 0, C_VD, 0, 1, 32'd1));
        tbl.push_back(mk(1, 0, A_ST,  0, 0, C_RD | C_VD, 32'd2, 1, 32'd1));
        tbl.push_back(mk(1, 1, A_OUT, 32'd5, 0, C_VD, 0, 1, 32'd1));
        tbl.push_back(mk(1, 0, A_ST,  0, 1, C_RD | C_VD, 32'd6, 1, 32'd1));
        tbl.push_back(mk(1, 0, A_ST,  0, 1, C_RD | C_VD, 32'd4, 1, 32'd2));
        tbl.push_back(mk(1, 0, A_ST,  0, 1, C_RD | C_VD, 32'd4, 1, 32'd3));
        tbl.push_back(mk(1, 0, A_ST,  0, 1, C_RD | C_VD, 32'd4, 1, 32'd4));
        tbl.push_back(mk(1, 0, A_ST,  0, 1, C_RD | C_V, 32'd5, 0, 0));
        tbl.push_back(mk(1, 1, A_ST,  32'd4, 0, C_RD, 32'd5, 0, 0));
        tbl.push_back(mk(1, 0, A_ST,  0, 0, C_RD, 32'd1, 0, 0));
        // push while full with a simultaneous pop is still dropped
        tbl.push_back(mk(1, 1, A_OUT, 32'd11, 0, C_V, 0, 0, 0));
        tbl.push_back(mk(1, 1, A_OUT, 32'd12, 0, C_VD, 0, 1, 32'd11));
        tbl.push_back(mk(1, 1, A_OUT, 32'd13, 0, C_VD, 0, 1, 32'd11));
        tbl.push_back(mk(1, 1, A_OUT, 32'd14, 0, C_VD, 0, 1, 32'd11));
        tbl.push_back(mk(1, 1, A_OUT, 32'd9,  1, C_VD, 0, 1, 32'd11));
        tbl.push_back(mk(1, 0, A_ST,  0, 1, C_RD | C_VD, 32'd4, 1, 32'd12));
        tbl.push_back(mk(1, 0, A_OUT, 0, 1, C_VD, 0, 1, 32'd13));
        tbl.push_back(mk(1, 0, A_OUT, 0, 1, C_VD, 0, 1, 32'd14));
        tbl.push_back(mk(1, 0, A_OUT, 0, 1, C_RD | C_V, 32'd0, 0, 0));
        tbl.push_back(mk(1, 1, A_ST,  32'd4, 0, C_RD, 32'd5, 0, 0));
        tbl.push_back(mk(1, 0, A_ST,  0, 0, C_RD, 32'd1, 0, 0));
        // reset mid-drain overrides a simultaneous counter write; RAM survives
        tbl.push_back(mk(1, 1, A_OUT, 32'd31, 0, C_V, 0, 0, 0));
        tbl.push_back(mk(1, 1, A_OUT, 32'd32, 0, C_VD, 0, 1, 32'd31));
        tbl.push_back(mk(0, 1, A_CYC, 32'h55, 1, C_VD, 0, 1, 32'd31));
        tbl.push_back(mk(1, 0, A_CYC, 0, 0, C_RD | C_V, 32'd0, 0, 0));
        tbl.push_back(mk(1, 0, A_ST,  0, 0, C_RD | C_V, 32'd1, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0000_0010, 0, 0, C_RD, 32'hCAFE_F00D, 0, 0));
        tbl.push_back(mk(1, 0, 32'h4000_0000, 0, 0, C_RD, 32'h0, 0, 0));

        foreach (tbl[i]) step(tbl[i], $sformatf("v%0d", i));

        // back-to-back push/pop with one entry resident: each word exits the cycle after its push
        step(mk(1, 1, A_OUT, 32'd100, 0, C_V, 0, 0, 0), "s0");
        for (int k = 1; k <= 5; k++)
            step(mk(1, 1, A_OUT, 32'd100 + k, 1, C_VD, 0, 1, 32'd100 + k - 1),
                 $sformatf("s%0d", k));
        step(mk(1, 0, A_ST, 0, 1, C_RD | C_VD, 32'd0, 1, 32'd105), "s6");
        step(mk(1, 0, A_ST, 0, 0, C_RD | C_V, 32'd1, 0, 0), "s7");

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
